// File: rtl/posit_pkg.sv
// Shared posit<N,ES> widths, special encodings and the decoded-operand struct.
// The struct is sized from PositN/PositEs; override the core's N/ES together with these.
package posit_pkg;

    localparam int unsigned PositN  = 32;
    localparam int unsigned PositEs = 4;
    localparam int unsigned PositRs = $clog2(PositN);

    // Signed scale k*2^ES + e, and hidden 1 plus the widest possible fraction.
    localparam int unsigned ScaleW = PositRs + PositEs + 2;
    localparam int unsigned MantW  = PositN - PositEs - 2;

    localparam logic [PositN-1:0] PositZero   = {PositN{1'b0}};
    localparam logic [PositN-1:0] PositNar    = {1'b1, {(PositN-1){1'b0}}};
    localparam logic [PositN-1:0] PositMaxpos = {1'b0, {(PositN-1){1'b1}}};
    localparam logic [PositN-1:0] PositMinpos = {{(PositN-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic              sign;
        logic              is_zero;
        logic              is_nar;
        logic [ScaleW-1:0] scale;
        logic [MantW-1:0]  mant;
    } posit_dec_t;

endpackage

// File: rtl/posit_decode.sv
// Posit bit pattern -> sign, special flags, signed scale and mantissa with hidden 1.
module posit_decode
    import posit_pkg::*;
#(
    parameter int unsigned N  = PositN,
    parameter int unsigned ES = PositEs
) (
    input  logic [N-1:0] bits,
    output posit_dec_t   dec
);

    localparam int unsigned FW = MantW - 1;

    logic [N-2:0] body;
    logic [N-4:0] rest;
    logic         r0;
    logic         done;
    int           run;
    int           scale_i;

    assign body = bits[N-1] ? (~bits[N-2:0] + {{(N-2){1'b0}}, 1'b1}) : bits[N-2:0];
    assign r0   = body[N-2];

    always_comb begin
        run  = 0;
        done = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!done && (body[i] == r0)) run = run + 1;
            else done = 1'b1;
        end
        // Drop regime and terminator; bits shifted in from the right read as 0.
        rest    = body[N-4:0] << (run - 1);
        scale_i = (r0 ? run - 1 : -run) * (1 << ES) + int'(rest[N-4 -: ES]);
    end

    always_comb begin
        dec.sign    = bits[N-1];
        dec.is_zero = (bits == {N{1'b0}});
        dec.is_nar  = (bits == {1'b1, {(N-1){1'b0}}});
        dec.scale   = ScaleW'(scale_i);
        dec.mant    = {1'b1, rest[FW-1:0]};
    end

endmodule

// File: rtl/posit_adder.sv
// posit<N,ES> adder: decode, align, add, normalise, round-to-nearest-even, encode.
// One output register; everything before it is combinational.
module posit_adder
    import posit_pkg::*;
#(
    parameter int unsigned N  = PositN,
    parameter int unsigned ES = PositEs
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] IN1,
    input  logic [N-1:0] IN2,
    output logic [N-1:0] OUT
);

    localparam int unsigned RS = $clog2(N);
    localparam int unsigned AW = MantW + 3;
    localparam int unsigned BW = 1 + ES + AW;
    localparam int unsigned VW = N + BW;

    posit_dec_t da, db;

    posit_decode #(.N(N), .ES(ES)) u_dec_a (.bits(IN1), .dec(da));
    posit_decode #(.N(N), .ES(ES)) u_dec_b (.bits(IN2), .dec(db));

    logic              swap, big_sign, sub, found, too_big, too_small, guard, sticky;
    logic [ScaleW-1:0] big_scale, diff;
    logic [MantW-1:0]  big_mant, small_mant;
    logic [2*AW-1:0]   wide;
    logic [AW-1:0]     ma, mb, frac;
    logic [AW:0]       s;
    logic [ES-1:0]     ev;
    logic [RS-1:0]     rsh;
    logic [VW-1:0]     v;
    logic [N-2:0]      mag, res_mag;
    logic [N-1:0]      mag_r, neg_in2, sum_d;
    int unsigned       sh;
    int                lz, sc, k;

    always_comb begin
        swap = ($signed(db.scale) > $signed(da.scale)) ||
               ((db.scale == da.scale) && (db.mant > da.mant));
        big_sign   = swap ? db.sign  : da.sign;
        big_scale  = swap ? db.scale : da.scale;
        big_mant   = swap ? db.mant  : da.mant;
        small_mant = swap ? da.mant  : db.mant;
        sub        = da.sign ^ db.sign;
        diff       = big_scale - (swap ? da.scale : db.scale);

        // Everything shifted below the guard/round bits folds into the sticky lsb.
        sh   = (diff > ScaleW'(AW)) ? AW : 32'(diff);
        ma   = {big_mant, 3'b000};
        wide = {small_mant, 3'b000, {AW{1'b0}}} >> sh;
        mb   = {wide[2*AW-1:AW+1], wide[AW] | (|wide[AW-1:0])};
        s    = sub ? ({1'b0, ma} - {1'b0, mb}) : ({1'b0, ma} + {1'b0, mb});

        lz    = 0;
        found = 1'b0;
        for (int i = AW; i >= 0; i--) begin
            if (s[i]) found = 1'b1;
            else if (!found) lz = lz + 1;
        end
        frac = AW'(s << lz);
        sc   = int'($signed(big_scale)) + 1 - lz;

        k         = sc >>> ES;
        ev        = ES'(sc);
        too_big   = k > (int'(N) - 2);
        too_small = k < (2 - int'(N));
        rsh       = (k >= 0) ? RS'(k + 1) : RS'(-k);

        // Terminator, exponent and fraction slide right behind a run of regime bits.
        v = {(k < 0), ev, frac, {N{1'b0}}} >> rsh;
        if (k >= 0) v = v | ~({VW{1'b1}} >> rsh);

        mag    = v[VW-1 -: N-1];
        guard  = v[VW-N];
        sticky = |v[VW-N-1:0];
        mag_r  = {1'b0, mag} + {{(N-1){1'b0}}, guard & (mag[0] | sticky)};

        if (too_big || mag_r[N-1])          res_mag = PositMaxpos[N-2:0];
        else if (too_small || mag_r == '0)  res_mag = PositMinpos[N-2:0];
        else                                res_mag = mag_r[N-2:0];

        neg_in2 = ~IN2 + {{(N-1){1'b0}}, 1'b1};
        if (da.is_nar || db.is_nar)            sum_d = PositNar;
        else if (da.is_zero)                   sum_d = IN2;
        else if (db.is_zero)                   sum_d = IN1;
        else if ((IN1 == neg_in2) || (s == '0)) sum_d = PositZero;
        else if (big_sign)                     sum_d = ~{1'b0, res_mag} + {{(N-1){1'b0}}, 1'b1};
        else                                   sum_d = {1'b0, res_mag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) OUT <= PositZero;
        else        OUT <= sum_d;
    end

endmodule

// File: tb/tb_posit_adder.sv
// Scoreboard bench for posit_adder: expected sums queued at drive time, checked one cycle later.
module tb_posit_adder;

    localparam int N = 32;
    localparam logic [N-1:0] Nar = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] in1, in2, out;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [N-1:0] exp_q[$];
    string        tag_q[$];

    always #5 clk = ~clk;

    posit_adder #(.N(32), .ES(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .IN1  (in1),
        .IN2  (in2),
        .OUT  (out)
    );

    task automatic check_eq(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] e);
        @(negedge clk);
        in1 = a;
        in2 = b;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Each entry pushed at a falling edge is due just after the following rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) check_eq(tag_q.pop_front(), out, exp_q.pop_front());
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] x;

        rst_n = 1'b0;
        in1   = 32'h7F1C_9F2D;
        in2   = 32'h4000_0000;
        repeat (3) begin
            @(negedge clk);
            check_eq("reset", out, 32'h0);
        end
        rst_n = 1'b1;

        drive("x_plus_neg_x", 32'h7F1C_9F2D, 32'h80E3_60D3, 32'h0000_0000);
        drive("huge_plus_1",  32'h7F1C_9F2D, 32'h4000_0000, 32'h7F1C_9F2D);
        drive("neghuge_p1",   32'h80E3_60D3, 32'h4000_0000, 32'h80E3_60D3);
        drive("one_plus_one", 32'h4000_0000, 32'h4000_0000, 32'h4200_0000);
        drive("one_minus_1",  32'h4000_0000, 32'hC000_0000, 32'h0000_0000);
        drive("nar_in1",      32'h8000_0000, 32'hA92A_A456, 32'h8000_0000);
        drive("zero_in1",     32'h0000_0000, 32'h54AA_A545, 32'h54AA_A545);
        drive("zero_in2",     32'h4954_A722, 32'h0000_0000, 32'h4954_A722);
        drive("maxpos_sat",   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        drive("minpos_keep",  32'h0000_0001, 32'h0000_0001, 32'h0000_0001);
        drive("maxpos_p1",    32'h7FFF_FFFF, 32'h4000_0000, 32'h7FFF_FFFF);
        drive("3_plus_1",     32'h4300_0000, 32'h4000_0000, 32'h4400_0000);
        drive("half_p1",      32'h3E00_0000, 32'h4000_0000, 32'h4100_0000);
        drive("2_minus_1",    32'h4200_0000, 32'hC000_0000, 32'h4000_0000);
        drive("1_minus_1p5",  32'h4000_0000, 32'hBF00_0000, 32'hC200_0000);
        drive("m1_plus_half", 32'hC000_0000, 32'h3E00_0000, 32'hC200_0000);
        drive("m1_plus_m1",   32'hC000_0000, 32'hC000_0000, 32'hBE00_0000);
        drive("regime_up",    32'h5E00_0000, 32'h5E00_0000, 32'h6000_0000);
        drive("regime_up_n",  32'hA200_0000, 32'hA200_0000, 32'hA000_0000);
        drive("tie_even_dn",  32'h4000_0000, 32'h1600_0000, 32'h4000_0000);
        drive("one_ulp",      32'h4000_0000, 32'h1700_0000, 32'h4000_0001);
        drive("tie_even_up",  32'h4000_0001, 32'h1600_0000, 32'h4000_0002);
        drive("above_tie",    32'h4000_0000, 32'h1780_0000, 32'h4000_0002);
        drive("sub_exact",    32'h4000_0000, 32'hEA00_0000, 32'h3FFF_FFFF);
        drive("sub_tie",      32'h4000_0000, 32'hEB00_0000, 32'h4000_0000);

        // Mid-stream reset clears OUT at once; the first edge after release loads a real sum.
        drive("pre_reset",    32'h4000_0000, 32'h4000_0000, 32'h4200_0000);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1 check_eq("async_clear", out, 32'h0);
        @(posedge clk);
        #1 check_eq("held_in_reset", out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        in1   = 32'h4300_0000;
        in2   = 32'h4000_0000;
        exp_q.push_back(32'h4400_0000);
        tag_q.push_back("first_after_reset");

        for (int i = 0; i < 16; i++) begin
            x = $urandom();
            drive("rnd_x_neg_x", x, -x, (x == Nar) ? Nar : 32'h0);
            drive("rnd_x_zero",  x, 32'h0, x);
            drive("rnd_zero_x",  32'h0, x, x);
            drive("rnd_nar_x",   Nar, x, Nar);
        end

        repeat (3) @(negedge clk);
        check_eq("drain", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
